// File: rtl/ysyx_040066_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_040066_irq_ctrl
//  Brief    : Machine-mode trap/interrupt controller. Holds the M-mode trap
//             CSRs, takes CLINT timer interrupts (drain, then redirect) and
//             ecall/mret at commit, and redirects fetch.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_040066_irq_ctrl #(
    parameter logic [63:0] MTVEC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        intr,
    input  logic [11:0] csr_addr,
    input  logic        csr_wen,
    input  logic [63:0] csr_wdata,
    output logic [63:0] csr_rdata,
    output logic        csr_err,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic [63:0] commit_npc,
    input  logic        commit_ecall,
    input  logic        commit_mret,
    input  logic        pipe_empty,
    output logic        stall_fetch,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    localparam logic [63:0] c_ALIGN_MASK  = ~64'd3;
    localparam logic [63:0] c_CAUSE_ECALL = 64'd11;
    localparam logic [63:0] c_CAUSE_MTI   = 64'h8000_0000_0000_0007;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_mie;
    logic        r_mpie;
    logic        r_mtie;
    logic        r_mtip_q;
    logic [63:0] r_mtvec;
    logic [63:0] r_mscratch;
    logic [63:0] r_mepc;
    logic [63:0] r_mcause;
    logic [63:0] r_last_npc;
    logic [63:0] r_tgt;
    logic        r_csr_err;

    logic [63:0] w_tgt_nxt;
    logic        w_do_ecall;
    logic        w_do_mret;
    logic        w_do_irq;
    logic        w_take_irq;
    logic        w_csr_hit;
    logic [63:0] w_mstatus;

    assign w_take_irq = r_mtip_q & r_mie & r_mtie;
    // MPP is hardwired to M-mode; only MIE and MPIE are stored.
    assign w_mstatus  = {51'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

    // Combinational CSR read mux; unimplemented addresses read zero.
    always_comb begin
        csr_rdata = 64'd0;
        w_csr_hit = 1'b1;
        case (csr_addr)
            12'h300: csr_rdata = w_mstatus;
            12'h304: csr_rdata = {56'd0, r_mtie, 7'd0};
            12'h344: csr_rdata = {56'd0, r_mtip_q, 7'd0};
            12'h305: csr_rdata = r_mtvec;
            12'h340: csr_rdata = r_mscratch;
            12'h341: csr_rdata = r_mepc;
            12'h342: csr_rdata = r_mcause;
            default: w_csr_hit = 1'b0;
        endcase
    end

    // Next-state and trap decision; a committing ecall/mret beats a pending interrupt.
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_do_ecall  = 1'b0;
        w_do_mret   = 1'b0;
        w_do_irq    = 1'b0;
        case (r_state)
            S_IDLE, S_DRAIN: begin
                w_do_ecall = commit_valid & commit_ecall;
                w_do_mret  = commit_valid & commit_mret & ~commit_ecall;
                if (w_do_ecall) begin
                    w_tgt_nxt   = r_mtvec;
                    w_state_nxt = S_REDIR;
                end else if (w_do_mret) begin
                    w_tgt_nxt   = r_mepc;
                    w_state_nxt = S_REDIR;
                end else if (r_state == S_IDLE) begin
                    if (w_take_irq) begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (pipe_empty && !commit_valid) begin
                    // Once draining, the interrupt is committed to regardless of CSR/intr changes.
                    w_do_irq    = 1'b1;
                    w_tgt_nxt   = r_mtvec;
                    w_state_nxt = S_REDIR;
                end
            end
            S_REDIR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and redirect target registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tgt   <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    // CSR state: software writes first, trap side effects override the fields they touch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtie     <= 1'b0;
            r_mtip_q   <= 1'b0;
            r_mtvec    <= MTVEC_RESET & c_ALIGN_MASK;
            r_mscratch <= 64'd0;
            r_mepc     <= 64'd0;
            r_mcause   <= 64'd0;
            r_last_npc <= 64'd0;
            r_csr_err  <= 1'b0;
        end else begin
            r_mtip_q  <= intr;
            r_csr_err <= csr_wen & ~w_csr_hit;
            if (commit_valid) begin
                r_last_npc <= commit_npc;
            end
            if (csr_wen) begin
                case (csr_addr)
                    12'h300: begin
                        r_mie  <= csr_wdata[3];
                        r_mpie <= csr_wdata[7];
                    end
                    12'h304: r_mtie     <= csr_wdata[7];
                    12'h305: r_mtvec    <= csr_wdata & c_ALIGN_MASK;
                    12'h340: r_mscratch <= csr_wdata;
                    12'h341: r_mepc     <= csr_wdata & c_ALIGN_MASK;
                    12'h342: r_mcause   <= csr_wdata;
                    default: ;
                endcase
            end
            if (w_do_ecall) begin
                r_mepc   <= commit_pc & c_ALIGN_MASK;
                r_mcause <= c_CAUSE_ECALL;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (w_do_irq) begin
                r_mepc   <= r_last_npc & c_ALIGN_MASK;
                r_mcause <= c_CAUSE_MTI;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (w_do_mret) begin
                r_mie    <= r_mpie;
                r_mpie   <= 1'b1;
            end
        end
    end

    assign csr_err        = r_csr_err;
    assign stall_fetch    = (r_state == S_DRAIN);
    assign redirect_valid = (r_state == S_REDIR);
    assign redirect_pc    = r_tgt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_040066_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_040066_irq_ctrl
//  Brief    : Directed self-checking bench for ysyx_040066_irq_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_040066_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        intr;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_err;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [63:0] commit_npc;
    logic        commit_ecall;
    logic        commit_mret;
    logic        pipe_empty;
    logic        stall_fetch;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_040066_irq_ctrl #(.MTVEC_RESET(64'h0000_0000_8000_0000)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .intr           (intr),
        .csr_addr       (csr_addr),
        .csr_wen        (csr_wen),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_err        (csr_err),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_npc     (commit_npc),
        .commit_ecall   (commit_ecall),
        .commit_mret    (commit_mret),
        .pipe_empty     (pipe_empty),
        .stall_fetch    (stall_fetch),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wen   = 1'b1;
        tick();
        csr_wen   = 1'b0;
    endtask

    task automatic csr_rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic commit(input logic [63:0] pc, input logic [63:0] npc,
                          input logic ec, input logic mr);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_npc   = npc;
        commit_ecall = ec;
        commit_mret  = mr;
    endtask

    task automatic no_commit();
        commit_valid = 1'b0;
        commit_ecall = 1'b0;
        commit_mret  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; intr = 1'b0; csr_addr = 12'h0; csr_wen = 1'b0; csr_wdata = 64'd0;
        commit_pc = 64'd0; commit_npc = 64'd0; pipe_empty = 1'b1;
        no_commit();

        // 1: reset
        tick();
        rst_n = 1'b1;
        csr_rd("rst_mstatus", 12'h300, 64'h1800);
        csr_rd("rst_mtvec", 12'h305, 64'h8000_0000);
        chk("rst_stall", {63'd0, stall_fetch}, 64'd0);
        chk("rst_redir", {63'd0, redirect_valid}, 64'd0);
        chk("rst_err", {63'd0, csr_err}, 64'd0);

        // 2: CSR alignment and unimplemented access
        csr_wr(12'h305, 64'h8000_0103);
        csr_wr(12'h341, 64'h8000_0006);
        csr_rd("mtvec_align", 12'h305, 64'h8000_0100);
        csr_rd("mepc_align", 12'h341, 64'h8000_0004);
        chk("err_clear", {63'd0, csr_err}, 64'd0);
        csr_wr(12'h7C0, 64'h1234);
        chk("err_set", {63'd0, csr_err}, 64'd1);
        csr_rd("unimpl_rd", 12'h7C0, 64'd0);
        tick();
        chk("err_drop", {63'd0, csr_err}, 64'd0);

        // 3: timer interrupt with drain
        csr_wr(12'h300, 64'h8);
        csr_wr(12'h304, 64'h80);
        csr_rd("mstatus_mie", 12'h300, 64'h1808);
        csr_rd("mie_rd", 12'h304, 64'h80);
        intr = 1'b1; pipe_empty = 1'b0;
        commit(64'h8000_0010, 64'h8000_0014, 1'b0, 1'b0);
        tick();
        no_commit();
        chk("irq_lat1", {63'd0, stall_fetch}, 64'd0);
        tick();
        chk("irq_stall0", {63'd0, stall_fetch}, 64'd1);
        tick();
        chk("irq_stall1", {63'd0, stall_fetch}, 64'd1);
        tick();
        chk("irq_stall2", {63'd0, stall_fetch}, 64'd1);
        chk("irq_noredir", {63'd0, redirect_valid}, 64'd0);
        pipe_empty = 1'b1;
        tick();
        chk("irq_redir", {63'd0, redirect_valid}, 64'd1);
        chk("irq_pc", redirect_pc, 64'h8000_0100);
        chk("irq_unstall", {63'd0, stall_fetch}, 64'd0);
        csr_rd("irq_mepc", 12'h341, 64'h8000_0014);
        csr_rd("irq_mcause", 12'h342, 64'h8000_0000_0000_0007);
        csr_rd("irq_mstatus", 12'h300, 64'h1880);
        tick();
        chk("irq_pulse", {63'd0, redirect_valid}, 64'd0);
        tick();
        tick();
        chk("mie0_nostall", {63'd0, stall_fetch}, 64'd0);
        chk("mie0_noredir", {63'd0, redirect_valid}, 64'd0);
        csr_rd("mip_rd", 12'h344, 64'h80);
        intr = 1'b0;
        tick();
        tick();
        csr_rd("mip_clr", 12'h344, 64'h0);

        // 4: ecall
        commit(64'h8000_0020, 64'h8000_0024, 1'b1, 1'b0);
        tick();
        no_commit();
        chk("ecall_redir", {63'd0, redirect_valid}, 64'd1);
        chk("ecall_pc", redirect_pc, 64'h8000_0100);
        csr_rd("ecall_mepc", 12'h341, 64'h8000_0020);
        csr_rd("ecall_mcause", 12'h342, 64'd11);
        csr_rd("ecall_mstatus", 12'h300, 64'h1800);
        tick();

        // 5: mret, then ecall racing a ready interrupt
        csr_wr(12'h341, 64'h8000_0024);
        csr_wr(12'h300, 64'h80);
        commit(64'h8000_0030, 64'h8000_0034, 1'b0, 1'b1);
        tick();
        no_commit();
        chk("mret_redir", {63'd0, redirect_valid}, 64'd1);
        chk("mret_pc", redirect_pc, 64'h8000_0024);
        csr_rd("mret_mstatus", 12'h300, 64'h1888);
        tick();
        intr = 1'b1;
        tick();
        commit(64'h8000_0030, 64'h8000_0034, 1'b1, 1'b0);
        tick();
        no_commit();
        chk("race_redir", {63'd0, redirect_valid}, 64'd1);
        chk("race_stall", {63'd0, stall_fetch}, 64'd0);
        chk("race_pc", redirect_pc, 64'h8000_0100);
        csr_rd("race_mcause", 12'h342, 64'd11);
        csr_rd("race_mepc", 12'h341, 64'h8000_0030);
        csr_rd("race_mstatus", 12'h300, 64'h1880);
        tick();
        tick();
        chk("race_noirq", {63'd0, stall_fetch}, 64'd0);
        intr = 1'b0;

        // 6: reset during drain, then ecall during drain
        csr_wr(12'h300, 64'h88);
        intr = 1'b1; pipe_empty = 1'b0;
        tick();
        tick();
        chk("d6_stall", {63'd0, stall_fetch}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("d6_rst_stall", {63'd0, stall_fetch}, 64'd0);
        chk("d6_rst_redir", {63'd0, redirect_valid}, 64'd0);
        csr_rd("d6_rst_mstatus", 12'h300, 64'h1800);
        tick();
        chk("d6_post_redir", {63'd0, redirect_valid}, 64'd0);
        csr_wr(12'h300, 64'h8);
        csr_wr(12'h304, 64'h80);
        tick();
        chk("d7_stall", {63'd0, stall_fetch}, 64'd1);
        commit(64'h8000_0040, 64'h8000_0044, 1'b1, 1'b0);
        tick();
        no_commit();
        intr = 1'b0;
        chk("d7_redir", {63'd0, redirect_valid}, 64'd1);
        chk("d7_pc", redirect_pc, 64'h8000_0000);
        csr_rd("d7_mcause", 12'h342, 64'd11);
        csr_rd("d7_mepc", 12'h341, 64'h8000_0040);
        tick();
        tick();
        chk("d7_idle", {63'd0, stall_fetch}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
